// File: rtl/snake_engine.sv
// snake_engine: grid snake game (movement, food, collisions) plus registered per-pixel colour.
// Build option: define SNAKE_WRAP_EN to wrap the head at the grid edges instead of dying at the wall.
module snake_engine #(
    parameter int unsigned MOVE_FRAMES = 8,
    parameter int unsigned MAX_LEN     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] CounterX,
    input  logic [8:0] CounterY,
    input  logic       inDisplayArea,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       vga_R,
    output logic       vga_G,
    output logic       vga_B,
    output logic       game_over
);
    localparam int unsigned XW = 6;
    localparam int unsigned YW = 5;
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned FW = 8;

    localparam logic [XW-1:0] X_LAST    = XW'(39);
    localparam logic [YW-1:0] Y_LAST    = YW'(29);
    localparam logic [XW-1:0] X_SPAN    = XW'(40);
    localparam logic [YW-1:0] Y_SPAN    = YW'(30);
    localparam logic [XW-1:0] HEAD_X0   = XW'(20);
    localparam logic [YW-1:0] HEAD_Y0   = YW'(15);
    localparam logic [XW-1:0] FOOD_X0   = XW'(30);
    localparam logic [YW-1:0] FOOD_Y0   = YW'(15);
    localparam logic [LW-1:0] LEN0      = LW'(3);
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;

    typedef enum logic {S_PLAY, S_DEAD} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    state_t          state_q, state_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    dir_t            dir_q, dir_d;
    dir_t            pend_q, pend_d;
    logic [LW-1:0]   len_q, len_d;
    logic [XW-1:0]   food_x_q, food_x_d;
    logic [YW-1:0]   food_y_q, food_y_d;
    logic [XW-1:0]   seg_x_q [MAX_LEN];
    logic [XW-1:0]   seg_x_d [MAX_LEN];
    logic [YW-1:0]   seg_y_q [MAX_LEN];
    logic [YW-1:0]   seg_y_d [MAX_LEN];
    logic [2:0]      rgb_q, rgb_d;
    logic            game_over_q;

    logic            frame_tick_c;
    logic            step_c;
    logic            btn_any_c;
    dir_t            btn_dir_c;
    logic [XW-1:0]   new_x_c;
    logic [YW-1:0]   new_y_c;
    logic            wall_c;
    logic            eat_c;
    logic            hit_c;
    logic [XW-1:0]   lfsr_x_c;
    logic [YW-1:0]   lfsr_y_c;
    logic [XW-1:0]   pix_x_c;
    logic [YW-1:0]   pix_y_c;
    logic            is_head_c;
    logic            is_body_c;
    logic            is_food_c;

    // State register; reset wins over every other update in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_PLAY;
            fcnt_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            dir_q       <= D_RIGHT;
            pend_q      <= D_RIGHT;
            len_q       <= LEN0;
            food_x_q    <= FOOD_X0;
            food_y_q    <= FOOD_Y0;
            rgb_q       <= '0;
            game_over_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                seg_x_q[i] <= HEAD_X0 - XW'(i);
                seg_y_q[i] <= HEAD_Y0;
            end
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            lfsr_q      <= lfsr_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            len_q       <= len_d;
            food_x_q    <= food_x_d;
            food_y_q    <= food_y_d;
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
            rgb_q       <= rgb_d;
            game_over_q <= (state_d == S_DEAD);
        end
    end

    // Game next-state: frame pacing, direction, head move, eat/collide, restart.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        len_d    = len_q;
        food_x_d = food_x_q;
        food_y_d = food_y_q;
        seg_x_d  = seg_x_q;
        seg_y_d  = seg_y_q;
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        new_x_c  = seg_x_q[0];
        new_y_c  = seg_y_q[0];
        wall_c   = 1'b0;
        eat_c    = 1'b0;
        hit_c    = 1'b0;

        frame_tick_c = (CounterX == 10'd0) && (CounterY == 9'd480);
        step_c       = frame_tick_c && (fcnt_q == FW'(MOVE_FRAMES - 1));
        btn_any_c    = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)        btn_dir_c = D_UP;
        else if (btn_down) btn_dir_c = D_DOWN;
        else if (btn_left) btn_dir_c = D_LEFT;
        else               btn_dir_c = D_RIGHT;

        lfsr_x_c = lfsr_q[5:0];
        if (lfsr_x_c >= X_SPAN) lfsr_x_c = lfsr_x_c - X_SPAN;
        lfsr_y_c = lfsr_q[10:6];
        if (lfsr_y_c >= Y_SPAN) lfsr_y_c = lfsr_y_c - Y_SPAN;

        if (frame_tick_c) fcnt_d = step_c ? '0 : fcnt_q + FW'(1);
        if (step_c && (state_q == S_PLAY)) dir_d = pend_q;
        // Pending is checked against the direction in force after this cycle.
        if (btn_any_c && (btn_dir_c != opposite(dir_d))) pend_d = btn_dir_c;

        case (dir_d)
            D_UP: begin
                if (seg_y_q[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                    new_y_c = Y_LAST;
`else
                    wall_c = 1'b1;
`endif
                end else new_y_c = seg_y_q[0] - YW'(1);
            end
            D_DOWN: begin
                if (seg_y_q[0] == Y_LAST) begin
`ifdef SNAKE_WRAP_EN
                    new_y_c = '0;
`else
                    wall_c = 1'b1;
`endif
                end else new_y_c = seg_y_q[0] + YW'(1);
            end
            D_LEFT: begin
                if (seg_x_q[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                    new_x_c = X_LAST;
`else
                    wall_c = 1'b1;
`endif
                end else new_x_c = seg_x_q[0] - XW'(1);
            end
            default: begin
                if (seg_x_q[0] == X_LAST) begin
`ifdef SNAKE_WRAP_EN
                    new_x_c = '0;
`else
                    wall_c = 1'b1;
`endif
                end else new_x_c = seg_x_q[0] + XW'(1);
            end
        endcase

        eat_c = !wall_c && (new_x_c == food_x_q) && (new_y_c == food_y_q);
        // The tail vacates its cell on a plain move, so it only counts when eating.
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_q) && (eat_c || (LW'(i) != len_q - LW'(1))) &&
                (seg_x_q[i] == new_x_c) && (seg_y_q[i] == new_y_c))
                hit_c = 1'b1;
        end

        if (state_q == S_PLAY) begin
            if (step_c) begin
                if (wall_c || hit_c) begin
                    state_d = S_DEAD;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = new_x_c;
                    seg_y_d[0] = new_y_c;
                    if (eat_c) begin
                        if (len_q != LW'(MAX_LEN)) len_d = len_q + LW'(1);
                        food_x_d = lfsr_x_c;
                        food_y_d = lfsr_y_c;
                    end
                end
            end
        end else if (btn_any_c) begin
            state_d  = S_PLAY;
            fcnt_d   = '0;
            dir_d    = D_RIGHT;
            pend_d   = D_RIGHT;
            len_d    = LEN0;
            food_x_d = FOOD_X0;
            food_y_d = FOOD_Y0;
            for (int i = 0; i < 3; i++) begin
                seg_x_d[i] = HEAD_X0 - XW'(i);
                seg_y_d[i] = HEAD_Y0;
            end
        end
    end

    // Pixel colour for the cell under the beam: head > body > food > black.
    always_comb begin
        pix_x_c   = CounterX[9:4];
        pix_y_c   = CounterY[8:4];
        is_head_c = (seg_x_q[0] == pix_x_c) && (seg_y_q[0] == pix_y_c);
        is_body_c = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_q) && (seg_x_q[i] == pix_x_c) && (seg_y_q[i] == pix_y_c))
                is_body_c = 1'b1;
        end
        is_food_c = (food_x_q == pix_x_c) && (food_y_q == pix_y_c);
        rgb_d     = 3'b000;
        if (inDisplayArea) begin
            if (is_head_c)      rgb_d = 3'b110;
            else if (is_body_c) rgb_d = (state_q == S_DEAD) ? 3'b100 : 3'b010;
            else if (is_food_c) rgb_d = 3'b100;
        end
    end

    assign vga_R     = rgb_q[2];
    assign vga_G     = rgb_q[1];
    assign vga_B     = rgb_q[0];
    assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed scenarios plus randomized play against a queue-based game model.
module tb_snake_engine;
    localparam int MF = 8;
    localparam int ML = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] cx;
    logic [8:0] cy;
    logic       ide;
    logic       bu, bd, bl, br;
    logic       r, g, b, go;

    always #5 clk = ~clk;

    snake_engine #(.MOVE_FRAMES(MF), .MAX_LEN(ML)) dut (
        .clk(clk), .reset(reset), .CounterX(cx), .CounterY(cy), .inDisplayArea(ide),
        .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
        .vga_R(r), .vga_G(g), .vga_B(b), .game_over(go)
    );

    // Model: directions 0=up 1=down 2=left 3=right; snake as queues, head first.
    int          m_x[$];
    int          m_y[$];
    int          m_dir, m_pend, m_fx, m_fy, m_fcnt;
    bit          m_dead;
    logic [15:0] m_lfsr;
    int          n_checks, n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dxf(input int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    function automatic int dyf(input int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction

    task automatic m_init();
        m_x.delete(); m_y.delete();
        for (int i = 0; i < 3; i++) begin
            m_x.push_back(20 - i);
            m_y.push_back(15);
        end
        m_dir = 3; m_pend = 3; m_fx = 30; m_fy = 15; m_fcnt = 0; m_dead = 0;
    endtask

    task automatic model_move();
        int nx, ny, n;
        bit wall, eat, hit;
        nx = m_x[0] + dxf(m_dir);
        ny = m_y[0] + dyf(m_dir);
        wall = 0;
`ifdef SNAKE_WRAP_EN
        nx = (nx + 40) % 40;
        ny = (ny + 30) % 30;
`else
        wall = (nx < 0) || (nx > 39) || (ny < 0) || (ny > 29);
`endif
        eat = !wall && (nx == m_fx) && (ny == m_fy);
        n = m_x.size();
        hit = 0;
        for (int i = 0; i < n; i++)
            if (!(i == n - 1 && !eat) && m_x[i] == nx && m_y[i] == ny) hit = 1;
        if (wall || hit) begin
            m_dead = 1;
        end else begin
            m_x.push_front(nx); m_y.push_front(ny);
            if (!eat || n == ML) begin
                void'(m_x.pop_back()); void'(m_y.pop_back());
            end
            if (eat) begin
                m_fx = int'(m_lfsr[5:0]);  if (m_fx >= 40) m_fx -= 40;
                m_fy = int'(m_lfsr[10:6]); if (m_fy >= 30) m_fy -= 30;
            end
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_eval();
        bit tick, step, any;
        int req;
        if (reset) begin
            m_init();
            m_lfsr = 16'hACE1;
            return;
        end
        any  = bu | bd | bl | br;
        req  = bu ? 0 : bd ? 1 : bl ? 2 : 3;
        tick = (cx == 10'd0) && (cy == 9'd480);
        step = tick && (m_fcnt == MF - 1);
        if (tick) m_fcnt = step ? 0 : m_fcnt + 1;
        if (m_dead && any) begin
            m_init();
        end else begin
            if (step && !m_dead) begin
                m_dir = m_pend;
                model_move();
            end
            if (any && req != (m_dir ^ 1)) m_pend = req;
        end
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    endtask

    function automatic logic [2:0] exp_rgb(input int px, input int py);
        if (m_x[0] == px && m_y[0] == py) return 3'b110;
        for (int i = 1; i < m_x.size(); i++)
            if (m_x[i] == px && m_y[i] == py) return m_dead ? 3'b100 : 3'b010;
        if (m_fx == px && m_fy == py) return 3'b100;
        return 3'b000;
    endfunction

    task automatic cycle();
        model_eval();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_btn(input logic [3:0] v);
        bu = v[3]; bd = v[2]; bl = v[1]; br = v[0];
    endtask

    task automatic press(input int d);
        logic [3:0] v;
        v = 4'b1000 >> d;
        set_btn(v);
        cycle();
        set_btn(4'b0000);
    endtask

    task automatic tick();
        cx = 10'd0; cy = 9'd480;
        cycle();
        cx = 10'd1; cy = 9'd0;
    endtask

    task automatic step_n(input int n);
        repeat (n * MF) tick();
    endtask

    // Reset lands on a tick with random buttons; reset must override both.
    task automatic do_reset();
        reset = 1'b1; cx = 10'd0; cy = 9'd480;
        set_btn(4'($urandom_range(15, 0)));
        cycle();
        reset = 1'b0; set_btn(4'b0000); cx = 10'd1; cy = 9'd0;
    endtask

    task automatic read_cell(input int x, input int y, input string tag);
        logic [2:0] e;
        cx  = 10'(x * 16 + int'($urandom_range(15, 0)));
        cy  = 9'(y * 16 + int'($urandom_range(15, 0)));
        ide = 1'b1;
        e   = exp_rgb(x, y);
        cycle();
        check($sformatf("%s(%0d,%0d)", tag, x, y), {29'd0, r, g, b}, {29'd0, e});
        ide = 1'b0; cx = 10'd1; cy = 9'd0;
    endtask

    task automatic scan(input string tag);
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++) read_cell(x, y, tag);
        check({tag, "_go"}, {31'd0, go}, {31'd0, m_dead});
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: got still running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int want, d, p, hx, hy;
        logic [3:0] bv;
        n_checks = 0; n_errors = 0;
        set_btn(4'b0000);
        reset = 1'b1; ide = 1'b1; cx = 10'(20 * 16); cy = 9'(15 * 16);
        cycle(); cycle();
        check("rst_rgb", {29'd0, r, g, b}, 32'd0);
        check("rst_go", {31'd0, go}, 32'd0);
        reset = 1'b0; ide = 1'b0; cx = 10'd1; cy = 9'd0;
        read_cell(20, 15, "rst_head");  check("rst_head_c", {29'd0, r, g, b}, 32'd6);
        read_cell(18, 15, "rst_tail");  check("rst_tail_c", {29'd0, r, g, b}, 32'd2);
        read_cell(30, 15, "rst_food");  check("rst_food_c", {29'd0, r, g, b}, 32'd4);
        scan("rst_scan");

        // One step with no buttons: snake moves right.
        step_n(1);
        read_cell(21, 15, "step_head"); check("step_head_c", {29'd0, r, g, b}, 32'd6);
        read_cell(18, 15, "step_tail"); check("step_tail_c", {29'd0, r, g, b}, 32'd0);
        check("step_go", {31'd0, go}, 32'd0);

        // Reversal request is ignored.
        do_reset();
        set_btn(4'b0010);
        step_n(1);
        set_btn(4'b0000);
        read_cell(21, 15, "rev_head"); check("rev_head_c", {29'd0, r, g, b}, 32'd6);

        // Pulsed up turns the snake.
        do_reset();
        press(0);
        step_n(1);
        read_cell(20, 14, "up_head"); check("up_head_c", {29'd0, r, g, b}, 32'd6);
        read_cell(20, 15, "up_body"); check("up_body_c", {29'd0, r, g, b}, 32'd2);

        // Ten steps right reach the initial food at (30,15).
        do_reset();
        step_n(10);
        read_cell(30, 15, "eat_head"); check("eat_head_c", {29'd0, r, g, b}, 32'd6);
        read_cell(27, 15, "eat_len4"); check("eat_len4_c", {29'd0, r, g, b}, 32'd2);
        scan("eat_scan");

        // Continue to x=39, then one step past the edge.
        step_n(9);
        check("edge_go", {31'd0, go}, 32'd0);
        step_n(1);
`ifdef SNAKE_WRAP_EN
        check("wrap_go", {31'd0, go}, 32'd0);
        read_cell(0, 15, "wrap_head"); check("wrap_head_c", {29'd0, r, g, b}, 32'd6);
`else
        check("wall_go", {31'd0, go}, 32'd1);
        read_cell(39, 15, "wall_head"); check("wall_head_c", {29'd0, r, g, b}, 32'd6);
        read_cell(38, 15, "wall_body"); check("wall_body_c", {29'd0, r, g, b}, 32'd4);
`endif
        scan("edge_scan");

        // Steer greedily to food until length 5, then U-turn into the body.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            if (m_x.size() >= 5 && !m_dead) break;
            if (m_dead) begin
                press(3);
                continue;
            end
            hx = m_x[0]; hy = m_y[0];
            if (m_fx != hx) want = (m_fx > hx) ? 3 : 2;
            else            want = (m_fy > hy) ? 1 : 0;
            if (want == (m_dir ^ 1)) begin
                if (want >= 2) want = (m_fy > hy) ? 1 : (m_fy < hy) ? 0 : ((hy == 0) ? 1 : 0);
                else           want = (hx == 0) ? 3 : 2;
            end
            if (want != m_dir) press(want);
            step_n(1);
        end
        check("len5_reached", {31'd0, (m_x.size() >= 5 && !m_dead)}, 32'd1);
        d = m_dir;
        if (d >= 2) p = (m_y[0] > 2) ? 0 : 1;
        else        p = (m_x[0] > 2) ? 2 : 3;
        press(p);     step_n(1);
        press(d ^ 1); step_n(1);
        press(p ^ 1); step_n(1);
        check("self_go", {31'd0, go}, 32'd1);
        read_cell(m_x[1], m_y[1], "self_red");
        scan("self_scan");
        press(1);
        check("restart_go", {31'd0, go}, 32'd0);
        read_cell(20, 15, "rs_head"); check("rs_head_c", {29'd0, r, g, b}, 32'd6);
        read_cell(30, 15, "rs_food"); check("rs_food_c", {29'd0, r, g, b}, 32'd4);

        // Randomized play: buttons on ticks and idle cycles, occasional reset.
        do_reset();
        for (int it = 0; it < 2000; it++) begin
            bv = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'd0;
            if ($urandom_range(99, 0) == 0) reset = 1'b1;
            set_btn(bv); cx = 10'd0; cy = 9'd480;
            cycle();
            reset = 1'b0; cx = 10'd1; cy = 9'd0;
            bv = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'd0;
            set_btn(bv);
            cycle();
            set_btn(4'b0000);
            check("rnd_go", {31'd0, go}, {31'd0, m_dead});
            read_cell(m_x[0], m_y[0], "rnd_head");
            read_cell(int'($urandom_range(39, 0)), int'($urandom_range(29, 0)), "rnd_cell");
            cx = 10'(m_x[0] * 16); cy = 9'(m_y[0] * 16); ide = 1'b0;
            cycle();
            check("rnd_blank", {29'd0, r, g, b}, 32'd0);
            cx = 10'd1; cy = 9'd0;
            if (it % 500 == 499) scan("rnd_scan");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 Parameter MOVE_FRAMES, default 8: frame ticks per snake step (legal range 1..255).
REQ-002 Parameter MAX_LEN, default 16: segment storage depth and length ceiling (legal range 4..32).
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 CounterX  input  10: horizontal pixel count from the sync generator.
REQ-006 CounterY  input  9: vertical pixel count from the sync generator.
REQ-007 inDisplayArea  input  1: high while the current pixel is visible.
REQ-008 btn_up, btn_down, btn_left, btn_right  input  1 each: level direction requests, already synchronised and debounced.
REQ-009 vga_R, vga_G, vga_B  output  1 each: registered pixel colour.
REQ-010 game_over  output  1: high while in state DEAD.

Function
REQ-011 Grid: 16x16-pixel cells; cell = (CounterX[9:4], CounterY[8:4]); playfield x 0..39, y 0..29.
REQ-012 Frame tick: single-cycle pulse when CounterX==0 and CounterY==480.
REQ-013 Frame counter: increments on each frame tick; at MOVE_FRAMES-1 it issues a step and returns to 0.
REQ-014 Pending direction register: loaded each cycle from the buttons, with priority up>down>left>right.
REQ-015 A pending request that is opposite to the current direction shall be ignored.
REQ-016 On a step, the current direction takes the pending value before the new head is computed.
REQ-017 A button change in the same cycle as a step affects only the next step.
REQ-018 Segment array seg[0..MAX_LEN-1]; seg[0] is the head; only seg[0..len-1] are live.
REQ-019 On a step in PLAY, new head = head +/-1 in the current direction, with seg[i] <= seg[i-1] for all i.
REQ-020 Eat: new head == food; len increments (saturating at MAX_LEN); food reloads from the LFSR.
REQ-021 Food load from the LFSR: fx = lfsr[5:0], minus 40 if >=40; fy = lfsr[10:6], minus 30 if >=30.
REQ-022 Food may land on the snake body; this is permitted.
REQ-023 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advances every clock.
REQ-024 Self-collision: new head equals any live segment, excluding seg[len-1] when not eating.
REQ-025 Wall collision: new head leaves the playfield (see REQ-036).
REQ-026 On any collision: transition PLAY->DEAD; segments, len and food freeze (the step is not applied).
REQ-027 DEAD->PLAY: on any button high; game state reinitialises to reset values (LFSR not reseeded).
REQ-028 States: PLAY and DEAD only; no other transitions exist.
REQ-029 Pixel colour priority, registered with 1-cycle latency, when inDisplayArea=1:
- head: R=1, G=1, B=0;
- body: R=0, G=1, B=0 (R=1, G=0 in DEAD);
- food: R=1, G=0, B=0;
- otherwise black.
REQ-030 Output is black when inDisplayArea=0.
REQ-031 Display reads state combinationally; a step landing mid-frame is acceptable because steps occur only at CounterY==480.

Reset
REQ-032 reset sets state=PLAY, game_over=0, vga_R/G/B=0, frame counter=0, lfsr=16'hACE1.
REQ-033 reset sets len=3, seg[0]=(20,15), seg[1]=(19,15), seg[2]=(18,15), direction=pending=right, food=(30,15).
REQ-034 Reset asserted mid-frame or mid-step overrides all other updates in that cycle.
REQ-035 Non-live segments need not be reset.

Configuration
REQ-036 Macro SNAKE_WRAP_EN: defined -> a head leaving the grid wraps (x 39<->0, y 29<->0), no wall death; undefined -> leaving the grid is a wall collision.

Verification
REQ-037 Reset, no buttons, 8 frame ticks -> head (21,15), len 3; the pixel at cell (21,15) reads yellow one clk later.
REQ-038 btn_left held from reset -> ignored (reversal); after 8 ticks head (21,15).
REQ-039 btn_up pulsed, then 8 ticks -> head (20,14).
REQ-040 Food forced at (21,15), 8 ticks -> len 4; food reloaded from the LFSR within the grid (fx<40, fy<30).
REQ-041 Run right to x=39 then one more step -> undefined: game_over=1, body red; SNAKE_WRAP_EN: head (0,15).
REQ-042 Length 5 turned up/left/down into itself -> DEAD; any button -> PLAY with reset snake.
